dmem_copy_engine: RTL and testbench

Word-copy initiator that drives the data memory's single port (Addr, WriteData, MemRead, MemWrite, ReadData) to move a block of words from a source to a destination region. It sits beside the MEM stage as a second data-memory master, arbitrated externally. It handles overlapping regions by choosing the copy direction, range-checks the request against the memory depth, and reports busy/done/err.

---
 rtl/dmem_copy_engine.sv | 164 ++++++++++++++++
 tb/tb_dmem_copy_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// Word-copy initiator for the data-memory port: moves a block of words from src to dst,
// choosing the copy direction so overlapping regions behave like a memmove.
module dmem_copy_engine #(
  parameter int unsigned MEM_DEPTH = 101,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      Addr,
  output logic [31:0]      WriteData,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      ReadData,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] wdone_q, wdone_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             bwd_q, bwd_d;

  logic [32:0]      src_last;
  logic [32:0]      dst_last;
  logic             range_err;
  logic             overlap_bwd;
  logic [LEN_W-1:0] offset;
  logic [31:0]      offset32;
  logic             more_words;

  // Last touched addresses in 33 bits so a 32-bit wrap still reads as out of range.
  always_comb begin
    src_last    = {1'b0, src_q} + 33'(len_q) - 33'd1;
    dst_last    = {1'b0, dst_q} + 33'(len_q) - 33'd1;
    range_err   = (len_q != '0) &&
                  ((src_last > 33'(MEM_DEPTH - 1)) || (dst_last > 33'(MEM_DEPTH - 1)));
    overlap_bwd = (dst_q > src_q) && ({1'b0, dst_q} <= src_last);
    offset      = bwd_q ? (len_q - LEN_W'(1) - idx_q) : idx_q;
    offset32    = 32'(offset);
    more_words  = ({1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1}) < {1'b0, len_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wdone_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      bwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wdone_q <= wdone_d;
      data_q  <= data_d;
      err_q   <= err_d;
      bwd_q   <= bwd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wdone_d = wdone_q;
    data_d  = data_q;
    err_d   = err_q;
    bwd_d   = bwd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          idx_d   = '0;
          wdone_d = '0;
          err_d   = 1'b0;
          bwd_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (range_err) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (len_q == '0) begin
          state_d = S_DONE;
        end else begin
          bwd_d   = overlap_bwd;
          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = ReadData;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_q + LEN_W'(1);
        wdone_d = wdone_q + LEN_W'(1);
        state_d = more_words ? S_READ : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    Addr      = '0;
    WriteData = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    unique case (state_q)
      S_READ: begin
        Addr    = src_q + offset32;
        MemRead = 1'b1;
      end
      S_WRITE: begin
        Addr      = dst_q + offset32;
        WriteData = data_q;
        MemWrite  = 1'b1;
      end
      default: begin
        Addr = '0;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign words_done = wdone_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: directed table, random jobs against a
// memmove reference, plus busy/start and mid-operation reset sequences.
module tb_dmem_copy_engine;

  localparam int DEPTH = 101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [7:0]  len;
  logic [31:0] Addr, WriteData, ReadData;
  logic        MemRead, MemWrite;
  logic        busy, done, err;
  logic [7:0]  words_done;

  logic [31:0] mem [0:DEPTH-1];

  int nvec = 0;
  int nfail = 0;

  dmem_copy_engine #(.MEM_DEPTH(DEPTH), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .Addr(Addr), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .ReadData(ReadData), .busy(busy), .done(done), .err(err), .words_done(words_done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on the falling edge.
  assign ReadData = (Addr < 32'(DEPTH)) ? mem[Addr[6:0]] : 32'hDEAD_BEEF;
  always @(negedge clk) begin
    if (MemWrite && (Addr < 32'(DEPTH))) mem[Addr[6:0]] <= WriteData;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_job(input string nm, input logic [31:0] s, input logic [31:0] d,
                         input logic [7:0] l, input logic exp_err, input int exp_lat,
                         input int exp_fr, input int exp_fw);
    int c, done_c, acc, fr, fw, bad;
    logic both;
    logic [31:0] tmp[$];
    logic [31:0] exp_m [0:DEPTH-1];
    exp_m = mem;
    if (!exp_err) begin
      for (int j = 0; j < int'(l); j++) tmp.push_back(mem[int'(s) + j]);
      for (int j = 0; j < int'(l); j++) exp_m[int'(d) + j] = tmp[j];
    end
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy@check"}, busy, 1);
    chk({nm, " err cleared"}, err, 0);
    chk({nm, " words cleared"}, words_done, 0);
    c = 1; done_c = -1; acc = 0; fr = -1; fw = -1; both = 1'b0;
    while (c < exp_lat + 8 && done_c < 0) begin
      if (MemRead && MemWrite) both = 1'b1;
      if (MemRead || MemWrite) acc++;
      if (MemRead && fr < 0) fr = int'(Addr);
      if (MemWrite && fw < 0) fw = int'(Addr);
      if (done) done_c = c;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk({nm, " done latency"}, done_c, exp_lat);
    chk({nm, " err"}, err, exp_err);
    chk({nm, " words_done"}, words_done, exp_err ? 0 : l);
    chk({nm, " accesses"}, acc, exp_err ? 0 : 2 * int'(l));
    chk({nm, " rd&wr overlap"}, both, 0);
    if (exp_fr >= 0) chk({nm, " first read addr"}, fr, exp_fr);
    if (exp_fw >= 0) chk({nm, " first write addr"}, fw, exp_fw);
    step(1);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " err sticky"}, err, exp_err);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_m[i]) bad++;
    chk({nm, " mem words wrong"}, bad, 0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] s, d;
    logic [7:0]  l;
    int          pbase;
    logic        e;
    int          lat, fr, fw;
  } vec_t;

  initial begin
    vec_t vt[$];
    int   c;
    logic seen;
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    int   c;
    logic seen;
    logic [31:0] s, d;
    logic [7:0]  l;
    logic        e;

    vt.push_back('{"fwd",      32'd0,  32'd40, 8'd4, 0, 1'b0, 10,  0, 40});
    vt.push_back('{"bwd",      32'd0,  32'd2,  8'd4, 0, 1'b0, 10,  3,  5});
    vt.push_back('{"fwd_ovl",  32'd2,  32'd0,  8'd4, 2, 1'b0, 10,  2,  0});
    vt.push_back('{"len0",     32'd0,  32'd40, 8'd0, 0, 1'b0,  2, -1, -1});
    vt.push_back('{"src_rng",  32'd98, 32'd0,  8'd4, 0, 1'b1,  2, -1, -1});
    vt.push_back('{"src_wrap", 32'hFFFF_FFFF, 32'd0, 8'd2, 0, 1'b1, 2, -1, -1});
    vt.push_back('{"dst_rng",  32'd0,  32'd98, 8'd4, 0, 1'b1,  2, -1, -1});
    vt.push_back('{"same",     32'd10, 32'd10, 8'd3, 0, 1'b0,  8, 10, 10});
    vt.push_back('{"edge_ok",  32'd97, 32'd0,  8'd4, 0, 1'b0, 10, 97,  0});

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;
    step(2);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset Addr", Addr, 0);
    chk("reset MemRead", MemRead, 0);
    chk("reset MemWrite", MemWrite, 0);
    chk("reset words_done", words_done, 0);
    rst_n = 1'b1;
    step(1);

    foreach (vt[k]) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;
      mem[vt[k].pbase]     = 32'd3;
      mem[vt[k].pbase + 1] = 32'd8;
      mem[vt[k].pbase + 2] = 32'd5;
      mem[vt[k].pbase + 3] = 32'd2;
      run_job(vt[k].nm, vt[k].s, vt[k].d, vt[k].l, vt[k].e, vt[k].lat, vt[k].fr, vt[k].fw);
    end

    // Randomized jobs checked against a memmove-style reference.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      s = 32'($urandom_range(0, 105));
      d = 32'($urandom_range(0, 105));
      l = 8'($urandom_range(0, 20));
      e = (l != 0) && ((longint'(s) + l - 1 > DEPTH - 1) || (longint'(d) + l - 1 > DEPTH - 1));
      run_job($sformatf("rnd%0d", r), s, d, l, e, (e || l == 0) ? 2 : 2 + 2 * int'(l), -1, -1);
    end

    // start during a WRITE must be ignored.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h2000 + i;
    mem[0] = 32'd3; mem[1] = 32'd8; mem[2] = 32'd5; mem[3] = 32'd2; mem[60] = 32'd777;
    src_addr = 32'd0; dst_addr = 32'd40; len = 8'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    c = 0;
    while (!MemWrite && c < 6) begin step(1); c++; end
    chk("busy_start write reached", MemWrite, 1);
    src_addr = 32'd5; dst_addr = 32'd60; len = 8'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    seen = 1'b0; c = 0;
    while (!seen && c < 20) begin
      if (done) seen = 1'b1; else begin step(1); c++; end
    end
    chk("busy_start done seen", seen, 1);
    chk("busy_start words_done", words_done, 4);
    step(4);
    chk("busy_start not queued", busy, 0);
    chk("busy_start mem40", mem[40], 3);
    chk("busy_start mem41", mem[41], 8);
    chk("busy_start mem42", mem[42], 5);
    chk("busy_start mem43", mem[43], 2);
    chk("busy_start mem60", mem[60], 777);

    // Reset asserted for the edge that ends the second WRITE.
    mem[0] = 32'd11; mem[1] = 32'd12; mem[2] = 32'd13; mem[3] = 32'd14;
    mem[40] = 32'hAA; mem[41] = 32'hAA; mem[42] = 32'hAA; mem[43] = 32'hAA;
    src_addr = 32'd0; dst_addr = 32'd40; len = 8'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    chk("rst_mid second write", MemWrite, 1);
    chk("rst_mid second addr", Addr, 41);
    rst_n = 1'b0;
    step(1);
    chk("rst_mid Addr", Addr, 0);
    chk("rst_mid WriteData", WriteData, 0);
    chk("rst_mid MemRead", MemRead, 0);
    chk("rst_mid MemWrite", MemWrite, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid err", err, 0);
    chk("rst_mid words_done", words_done, 0);
    rst_n = 1'b1;
    step(3);
    chk("rst_mid mem40", mem[40], 11);
    chk("rst_mid mem41", mem[41], 12);
    chk("rst_mid mem42", mem[42], 32'hAA);
    chk("rst_mid mem43", mem[43], 32'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
